// File: rtl/alu_m.sv
// EXU integer ALU: single-cycle base ops plus an optional iterative radix-2
// multiply/divide unit with fixed latency and a busy handshake.
module alu_m #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned M_EN = 1
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic            i_stall,
    input  logic            i_bubble,
    input  logic [XLEN-1:0] i_op0,
    input  logic [XLEN-1:0] i_op1,
    input  logic [4:0]      i_opcode,
    output logic [XLEN-1:0] o_result,
    output logic            o_bubble,
    output logic            o_busy
);
    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned AW  = 2 * XLEN;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLT  = 5'd2;
    localparam logic [4:0] OP_SLTU = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_SLL  = 5'd7;
    localparam logic [4:0] OP_SRL  = 5'd8;
    localparam logic [4:0] OP_SRA  = 5'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] mag_q, mag_d;
    logic [XLEN-1:0] op0_q, op0_d;
    logic [2:0]      sub_q, sub_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            bubble_q, bubble_d;
    logic            busy_q, busy_d;

    assign o_result = result_q;
    assign o_bubble = bubble_q;
    assign o_busy   = busy_q;

    // Single-cycle base operations
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res;
    logic            base_legal;

    assign shamt = i_op1[SHW-1:0];

    always_comb begin
        base_res   = '0;
        base_legal = 1'b1;
        case (i_opcode)
            OP_ADD:  base_res = i_op0 + i_op1;
            OP_SUB:  base_res = i_op0 - i_op1;
            OP_SLT:  base_res = XLEN'($signed(i_op0) < $signed(i_op1));
            OP_SLTU: base_res = XLEN'(i_op0 < i_op1);
            OP_XOR:  base_res = i_op0 ^ i_op1;
            OP_OR:   base_res = i_op0 | i_op1;
            OP_AND:  base_res = i_op0 & i_op1;
            OP_SLL:  base_res = i_op0 << shamt;
            OP_SRL:  base_res = i_op0 >> shamt;
            OP_SRA:  base_res = $unsigned($signed(i_op0) >>> shamt);
            default: base_legal = 1'b0;
        endcase
    end

    // M-op decode at acceptance: sub-op, operand signedness and magnitudes
    logic            is_mop;
    logic [2:0]      sub_in;
    logic            sgn0, sgn1, neg0, neg1;
    logic [XLEN-1:0] mag0, mag1;

    assign is_mop = (M_EN != 0) && (i_opcode[4:3] == 2'b10);
    assign sub_in = i_opcode[2:0];

    always_comb begin
        if (sub_in[2]) begin
            sgn0 = ~sub_in[0];
            sgn1 = ~sub_in[0];
        end else begin
            sgn0 = (sub_in != 3'd3);
            sgn1 = (sub_in == 3'd0) || (sub_in == 3'd1);
        end
    end

    assign neg0 = sgn0 & i_op0[XLEN-1];
    assign neg1 = sgn1 & i_op1[XLEN-1];
    assign mag0 = neg0 ? (~i_op0 + XLEN'(1)) : i_op0;
    assign mag1 = neg1 ? (~i_op1 + XLEN'(1)) : i_op1;

    // One radix-2 iteration: shift-add multiply or restoring divide
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN:0]   div_rem;
    logic [AW-1:0]   step_acc;

    always_comb begin
        mul_sum   = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
        div_shift = acc_q[AW-1:XLEN-1];
        div_ge    = (div_shift >= {1'b0, mag_q});
        div_rem   = div_ge ? (div_shift - {1'b0, mag_q}) : div_shift;
        if (sub_q[2]) begin
            step_acc = {div_rem[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
        end else begin
            step_acc = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Final value with sign fix-up and divide special cases
    logic [AW-1:0]   mul_full;
    logic [XLEN-1:0] quo, rem, m_final;

    always_comb begin
        mul_full = neg_res_q ? (~acc_q + AW'(1)) : acc_q;
        quo      = acc_q[XLEN-1:0];
        rem      = acc_q[AW-1:XLEN];
        m_final  = '0;
        if (!sub_q[2]) begin
            m_final = (sub_q == 3'd0) ? mul_full[XLEN-1:0] : mul_full[AW-1:XLEN];
        end else if (div0_q) begin
            m_final = sub_q[1] ? op0_q : '1;
        end else if (ovf_q) begin
            m_final = sub_q[1] ? '0 : op0_q;
        end else if (sub_q[1]) begin
            m_final = neg_rem_q ? (~rem + XLEN'(1)) : rem;
        end else begin
            m_final = neg_res_q ? (~quo + XLEN'(1)) : quo;
        end
    end

    // Next-state and output computation; everything holds while stalled
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mag_d     = mag_q;
        op0_d     = op0_q;
        sub_d     = sub_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        result_d  = result_q;
        bubble_d  = bubble_q;
        busy_d    = busy_q;
        if (!i_stall) begin
            case (state_q)
                S_IDLE: begin
                    if (i_bubble) begin
                        result_d = '0;
                        bubble_d = 1'b1;
                    end else if (is_mop) begin
                        state_d   = S_BUSY;
                        cnt_d     = '0;
                        sub_d     = sub_in;
                        op0_d     = i_op0;
                        mag_d     = sub_in[2] ? mag1 : mag0;
                        acc_d     = {{XLEN{1'b0}}, (sub_in[2] ? mag0 : mag1)};
                        neg_res_d = neg0 ^ neg1;
                        neg_rem_d = neg0;
                        div0_d    = (i_op1 == '0);
                        ovf_d     = sgn0 && (i_op0 == {1'b1, {(XLEN-1){1'b0}}}) && (i_op1 == '1);
                        bubble_d  = 1'b1;
                        busy_d    = 1'b1;
                    end else if (base_legal) begin
                        result_d = base_res;
                        bubble_d = 1'b0;
                    end else begin
                        result_d = '0;
                        bubble_d = 1'b1;
                    end
                end
                S_BUSY: begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + SHW'(1);
                    if (cnt_q == SHW'(XLEN - 1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    result_d = m_final;
                    bubble_d = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mag_q     <= '0;
            op0_q     <= '0;
            sub_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            result_q  <= '0;
            bubble_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mag_q     <= mag_d;
            op0_q     <= op0_d;
            sub_q     <= sub_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
            result_q  <= result_d;
            bubble_q  <= bubble_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_alu_m.sv
// Directed bench for alu_m: a 32-bit M-enabled instance and two 64-bit
// instances (M_EN=0 and M_EN=1) sharing clock, reset, stall and opcode.
module tb_alu_m;
    logic        clk = 1'b0;
    logic        aresetn;
    logic        stall;
    logic        bub32, bub64;
    logic [4:0]  opc;
    logic [31:0] a32, b32, r32;
    logic [63:0] a64, b64, r64n, r64m;
    logic        bo32, bsy32, bo64n, bsy64n, bo64m, bsy64m;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_m #(.XLEN(32), .M_EN(1)) dut32 (
        .clk(clk), .aresetn(aresetn), .i_stall(stall), .i_bubble(bub32),
        .i_op0(a32), .i_op1(b32), .i_opcode(opc),
        .o_result(r32), .o_bubble(bo32), .o_busy(bsy32)
    );

    alu_m #(.XLEN(64), .M_EN(0)) dut64n (
        .clk(clk), .aresetn(aresetn), .i_stall(stall), .i_bubble(bub64),
        .i_op0(a64), .i_op1(b64), .i_opcode(opc),
        .o_result(r64n), .o_bubble(bo64n), .o_busy(bsy64n)
    );

    alu_m #(.XLEN(64), .M_EN(1)) dut64m (
        .clk(clk), .aresetn(aresetn), .i_stall(stall), .i_bubble(bub64),
        .i_op0(a64), .i_op1(b64), .i_opcode(opc),
        .o_result(r64m), .o_bubble(bo64m), .o_busy(bsy64m)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic base32(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic expb);
        opc = op; a32 = a; b32 = b; bub32 = 1'b0;
        step();
        check({tag, ".res"}, 64'(r32), 64'(exp));
        check({tag, ".bub"}, 64'(bo32), 64'(expb));
    endtask

    // Accept an M op, count edges until busy falls, check latency and value
    task automatic mop32(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int cnt;
        opc = op; a32 = a; b32 = b; bub32 = 1'b0;
        step();
        check({tag, ".busy"}, 64'(bsy32), 64'd1);
        cnt = 0;
        while (bsy32 && cnt < 200) begin
            step();
            cnt++;
        end
        bub32 = 1'b1;
        check({tag, ".lat"}, 64'(cnt), 64'd33);
        check({tag, ".res"}, 64'(r32), 64'(exp));
        check({tag, ".bub"}, 64'(bo32), 64'd0);
    endtask

    initial begin
        int cnt;
        aresetn = 1'b0; stall = 1'b0; bub32 = 1'b1; bub64 = 1'b1;
        opc = 5'd0; a32 = '0; b32 = '0; a64 = '0; b64 = '0;
        step();
        step();
        check("rst.res", 64'(r32), 64'd0);
        check("rst.bub", 64'(bo32), 64'd1);
        check("rst.busy", 64'(bsy32), 64'd0);
        aresetn = 1'b1;
        step();
        step();
        check("idle.res", 64'(r32), 64'd0);
        check("idle.bub", 64'(bo32), 64'd1);
        check("idle.busy", 64'(bsy32), 64'd0);

        base32("add_wrap", 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b0);
        base32("sub", 5'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
        base32("sra31", 5'd9, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0);
        base32("slt", 5'd2, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        base32("sltu", 5'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        base32("xor", 5'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0);
        base32("or", 5'd5, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 1'b0);
        base32("and", 5'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0);
        base32("sll_mask", 5'd7, 32'd1, 32'd33, 32'd2, 1'b0);
        base32("srl", 5'd8, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
        base32("illegal12", 5'd12, 32'd5, 32'd6, 32'd0, 1'b1);
        base32("illegal31", 5'd31, 32'd5, 32'd6, 32'd0, 1'b1);
        bub32 = 1'b1;
        step();
        check("bubble.bub", 64'(bo32), 64'd1);

        mop32("mulh", 5'd17, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        mop32("mulhsu", 5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        mop32("mul", 5'd16, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        mop32("mulhu", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        mop32("div", 5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        mop32("rem", 5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        mop32("divu0", 5'd21, 32'd100, 32'd0, 32'hFFFF_FFFF);
        mop32("remu0", 5'd23, 32'd100, 32'd0, 32'd100);
        mop32("div0s", 5'd20, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        mop32("divovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        mop32("removf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        mop32("divu", 5'd21, 32'd100, 32'd7, 32'd14);
        base32("b2b_add", 5'd0, 32'd3, 32'd4, 32'd7, 1'b0);

        // Stall 5 cycles mid-BUSY and 3 cycles in DONE
        opc = 5'd20; a32 = 32'hFFFF_FFF9; b32 = 32'd2; bub32 = 1'b0;
        step();
        repeat (10) step();
        stall = 1'b1;
        repeat (5) step();
        stall = 1'b0;
        repeat (22) step();
        check("stall.busy_done", 64'(bsy32), 64'd1);
        stall = 1'b1;
        repeat (3) step();
        check("stall.busy_hold", 64'(bsy32), 64'd1);
        check("stall.bub_hold", 64'(bo32), 64'd1);
        stall = 1'b0;
        step();
        bub32 = 1'b1;
        check("stall.busy_end", 64'(bsy32), 64'd0);
        check("stall.res", 64'(r32), 64'hFFFF_FFFD);
        check("stall.bub", 64'(bo32), 64'd0);

        // Reset mid-divide aborts without issuing a result
        opc = 5'd21; a32 = 32'd100; b32 = 32'd7; bub32 = 1'b0;
        step();
        bub32 = 1'b1;
        repeat (5) step();
        aresetn = 1'b0;
        #1;
        check("rstmid.busy", 64'(bsy32), 64'd0);
        check("rstmid.res", 64'(r32), 64'd0);
        check("rstmid.bub", 64'(bo32), 64'd1);
        #1;
        aresetn = 1'b1;
        cnt = 0;
        repeat (40) begin
            step();
            if (!bo32 || bsy32) cnt++;
        end
        check("rstmid.no_issue", 64'(cnt), 64'd0);

        // 64-bit instances
        opc = 5'd16; a64 = 64'd3; b64 = 64'd5; bub64 = 1'b0;
        step();
        check("x64n.mul.bub", 64'(bo64n), 64'd1);
        check("x64n.mul.res", r64n, 64'd0);
        check("x64n.mul.busy", 64'(bsy64n), 64'd0);
        while (bsy64m) step();
        opc = 5'd7; a64 = 64'd1; b64 = 64'd63;
        step();
        check("x64n.sll63", r64n, 64'h8000_0000_0000_0000);
        check("x64m.sll63", r64m, 64'h8000_0000_0000_0000);
        opc = 5'd19; a64 = '1; b64 = '1;
        step();
        check("x64m.mulhu.busy", 64'(bsy64m), 64'd1);
        cnt = 0;
        while (bsy64m && cnt < 300) begin
            step();
            cnt++;
        end
        bub64 = 1'b1;
        check("x64m.mulhu.lat", 64'(cnt), 64'd65);
        check("x64m.mulhu.res", r64m, 64'hFFFF_FFFF_FFFF_FFFE);
        check("x64m.mulhu.bub", 64'(bo64m), 64'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
